// File: rtl/bus_pkg.sv
// Shared types, transfer-type codes and the round-robin pick helper for the
// bus_interconnect_rr shared-bus interconnect.
package bus_pkg;

    localparam int MAX_NM = 8;
    localparam int IDX_W  = 3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        WAIT = 2'd2
    } bus_state_e;

    // First requester at or after ptr, wrapping nm-1 -> 0; returns ptr if none.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_NM-1:0] req_vec,
        input logic [IDX_W-1:0]  ptr,
        input int                nm
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_NM; i++) begin
            idx = (int'(ptr) + i) % nm;
            if (!found && (i < nm) && req_vec[idx[IDX_W-1:0]]) begin
                pick  = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Ownership FSM for the shared bus: round-robin grant with lock, transfer
// tracking and, when BUS_TIMEOUT_EN is defined, a slave-ready timeout.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int NM      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NM-1:0]    req_i,
    input  logic             own_req_i,
    input  logic             own_as_i,
    input  logic             sel_rdy_i,
    output logic             owned_o,
    output logic             in_wait_o,
    output logic [IDX_W-1:0] owner_o,
    output logic             done_o,
    output logic             err_o
);

    bus_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] ptr_nxt;
    logic [MAX_NM-1:0] req_ext;
    logic             timeout;

    always_comb begin
        req_ext         = '0;
        req_ext[NM-1:0] = req_i;
    end

    assign ptr_nxt = (owner_q == IDX_W'(NM - 1)) ? '0 : owner_q + 1'b1;

`ifdef BUS_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q holds the WAIT cycles already elapsed, so the TIMEOUT-th one sees TIMEOUT-1.
    assign timeout = (state_q == WAIT) && !sel_rdy_i && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == OWN && own_as_i) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // NOTE: state uses <= so every flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // NOTE: hold-value defaults first, so no branch leaves a _d undriven and no latch is inferred.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = OWN;
                    owner_d = rr_pick(req_ext, ptr_q, NM);
                end
            end
            OWN: begin
                if (own_as_i) begin
                    state_d = WAIT;
                end else if (!own_req_i) begin
                    ptr_d = ptr_nxt;
                    if (|req_i) begin
                        owner_d = rr_pick(req_ext, ptr_nxt, NM);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT: begin
                if (sel_rdy_i || timeout) begin
                    state_d = OWN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owned_o   = (state_q != IDLE);
        in_wait_o = (state_q == WAIT);
        owner_o   = owner_q;
        done_o    = (state_q == WAIT) && (sel_rdy_i || timeout);
        err_o     = timeout;
    end

endmodule

// File: rtl/bus_interconnect_rr.sv
// NM-master / NS-slave shared bus: owner mux, slave decode and read-back mux
// around the round-robin arbiter. Define BUS_TIMEOUT_EN to bound slave waits.
module bus_interconnect_rr
    import bus_pkg::*;
#(
    parameter int NM      = 4,
    parameter int NS      = 8,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SEL_MSB = 31,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NM-1:0]    m_req_,
    output logic [NM-1:0]    m_grnt_,
    input  logic [NM*AW-1:0] m_addr,
    input  logic [NM-1:0]    m_as_,
    input  logic [NM-1:0]    m_rw,
    input  logic [NM-1:0]    m_busy,
    input  logic [NM*DW-1:0] m_wr_data,
    output logic [DW-1:0]    m_rd_data,
    output logic             m_rdy,
    output logic             m_err,
    output logic [AW-1:0]    s_addr,
    output logic             s_as_,
    output logic             s_rw,
    output logic [DW-1:0]    s_wr_data,
    output logic [1:0]       htrans,
    output logic [NS-1:0]    s_cs_,
    input  logic [NS*DW-1:0] s_rd_data,
    input  logic [NS-1:0]    s_rdy
);

    localparam int SW = $clog2(NS);

    logic             owned, in_wait, done, err;
    logic [IDX_W-1:0] owner;
    logic             own_req, own_as, own_busy, own_rw;
    logic [AW-1:0]    own_addr;
    logic [DW-1:0]    own_wdata;
    logic [SW-1:0]    addr_sel;
    logic [SW-1:0]    sel_q, sel_d;
    logic             sel_rdy;
    logic [DW-1:0]    slave_rd;

    bus_rr_arbiter #(
        .NM      (NM),
        .TIMEOUT (TIMEOUT)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (~m_req_),
        .own_req_i (own_req),
        .own_as_i  (own_as),
        .sel_rdy_i (sel_rdy),
        .owned_o   (owned),
        .in_wait_o (in_wait),
        .owner_o   (owner),
        .done_o    (done),
        .err_o     (err)
    );

    // Owner's signals in active-high form; idle bus values when nobody owns it.
    always_comb begin
        own_req   = 1'b0;
        own_as    = 1'b0;
        own_busy  = 1'b0;
        own_rw    = 1'b1;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < NM; i++) begin
            if (owned && owner == IDX_W'(i)) begin
                own_req   = ~m_req_[i];
                own_as    = ~m_as_[i];
                own_busy  = m_busy[i];
                own_rw    = m_rw[i];
                own_addr  = m_addr[i*AW +: AW];
                own_wdata = m_wr_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        m_grnt_ = '1;
        for (int i = 0; i < NM; i++) begin
            if (owned && owner == IDX_W'(i)) begin
                m_grnt_[i] = 1'b0;
            end
        end
    end

    assign s_addr    = own_addr;
    assign s_as_     = ~own_as;
    assign s_rw      = own_rw;
    assign s_wr_data = own_wdata;
    assign htrans    = own_busy ? HTRANS_BUSY : (own_as ? HTRANS_NONSEQ : HTRANS_IDLE);

    assign addr_sel = s_addr[SEL_MSB -: SW];

    always_comb begin
        s_cs_ = '1;
        for (int i = 0; i < NS; i++) begin
            if (own_as && addr_sel == SW'(i)) begin
                s_cs_[i] = 1'b0;
            end
        end
    end

    // The slave index is frozen at the strobe so WAIT ignores later address changes.
    assign sel_d = (owned && !in_wait && own_as) ? addr_sel : sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign sel_rdy = s_rdy[sel_q];

    always_comb begin
        slave_rd = '0;
        for (int i = 0; i < NS; i++) begin
            if (sel_q == SW'(i)) begin
                slave_rd = s_rd_data[i*DW +: DW];
            end
        end
    end

    assign m_rd_data = (in_wait && !err) ? slave_rd : '0;
    // A reset landing on the completing cycle aborts the transfer without a pulse.
    assign m_rdy     = done && !reset;

`ifdef BUS_TIMEOUT_EN
    assign m_err = err && !reset;
`else
    assign m_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_interconnect_rr.sv
// Self-checking bench for bus_interconnect_rr: scoreboarded transfers, grant
// rotation, lock during WAIT, reset abort and slave-ready timeout behaviour.
module tb_bus_interconnect_rr;

    localparam int NM = 4;
    localparam int NS = 8;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef BUS_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic             clk;
    logic             reset;
    logic [NM-1:0]    m_req_;
    logic [NM-1:0]    m_grnt_;
    logic [NM*AW-1:0] m_addr;
    logic [NM-1:0]    m_as_;
    logic [NM-1:0]    m_rw;
    logic [NM-1:0]    m_busy;
    logic [NM*DW-1:0] m_wr_data;
    logic [DW-1:0]    m_rd_data;
    logic             m_rdy;
    logic             m_err;
    logic [AW-1:0]    s_addr;
    logic             s_as_;
    logic             s_rw;
    logic [DW-1:0]    s_wr_data;
    logic [1:0]       htrans;
    logic [NS-1:0]    s_cs_;
    logic [NS*DW-1:0] s_rd_data;
    logic [NS-1:0]    s_rdy;

    bus_interconnect_rr #(
        .NM(NM), .NS(NS), .AW(AW), .DW(DW), .SEL_MSB(31), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req_    (m_req_),
        .m_grnt_   (m_grnt_),
        .m_addr    (m_addr),
        .m_as_     (m_as_),
        .m_rw      (m_rw),
        .m_busy    (m_busy),
        .m_wr_data (m_wr_data),
        .m_rd_data (m_rd_data),
        .m_rdy     (m_rdy),
        .m_err     (m_err),
        .s_addr    (s_addr),
        .s_as_     (s_as_),
        .s_rw      (s_rw),
        .s_wr_data (s_wr_data),
        .htrans    (htrans),
        .s_cs_     (s_cs_),
        .s_rd_data (s_rd_data),
        .s_rdy     (s_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rd;
        bit          is_read;
    } sb_t;

    sb_t sb[$];
    int  gq[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slave_word(input int j);
        return 32'hD000_0055 | (32'(j) << 8);
    endfunction

    function automatic logic [NS-1:0] cs_for(input int sel);
        logic [NS-1:0] v;
        v      = '1;
        v[sel] = 1'b0;
        return v;
    endfunction

    function automatic logic [NM-1:0] gnt_for(input int m);
        logic [NM-1:0] v;
        v    = '1;
        v[m] = 1'b0;
        return v;
    endfunction

    task automatic check_grant();
        int exp_m;
        if (gq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_q: no expected grant queued");
        end else begin
            exp_m = gq.pop_front();
            check("grant", 64'(m_grnt_), 64'(gnt_for(exp_m)));
        end
    endtask

    // Called at a negedge while master m owns the bus in OWN; returns in the
    // OWN cycle after completion with the strobe released.
    task automatic do_xfer(input int m, input logic [31:0] addr, input logic rw,
                           input logic [31:0] wd, input int lat, input bit drop_req);
        int  sel;
        sb_t e;
        sel = int'(addr[31:29]);
        check("grant_start", 64'(m_grnt_), 64'(gnt_for(m)));
        m_as_[m]             = 1'b0;
        m_rw[m]              = rw;
        m_addr[m*AW +: AW]   = addr;
        m_wr_data[m*DW +: DW] = wd;
        #1;
        check("htrans_nonseq", 64'(htrans), 64'(2'b10));
        check("cs_decode", 64'(s_cs_), 64'(cs_for(sel)));
        check("s_addr", 64'(s_addr), 64'(addr));
        check("s_rw", 64'(s_rw), 64'(rw));
        if (!rw) check("s_wr_data", 64'(s_wr_data), 64'(wd));
        check("rdy_in_own", 64'(m_rdy), 64'(0));
        e.addr    = addr;
        e.rd      = slave_word(sel);
        e.is_read = rw;
        sb.push_back(e);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            s_rdy     = '0;
            m_busy[m] = 1'b0;
            if (k == 0) begin
                s_rdy[(sel + 1) % NS] = 1'b1;
                if (drop_req) m_req_[m] = 1'b1;
            end
            if (k == 1) m_busy[m] = 1'b1;
            #1;
            check("rdy_in_wait", 64'(m_rdy), 64'(0));
            check("grant_locked", 64'(m_grnt_), 64'(gnt_for(m)));
            check("htrans_wait", 64'(htrans), (k == 1) ? 64'(2'b01) : 64'(2'b10));
        end
        @(negedge clk);
        m_busy[m]  = 1'b0;
        s_rdy      = '0;
        s_rdy[sel] = 1'b1;
        #1;
        check("rdy_done", 64'(m_rdy), 64'(1));
        check("err_done", 64'(m_err), 64'(0));
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb: completion with empty scoreboard");
        end else begin
            e = sb.pop_front();
            check("sb_addr", 64'(s_addr), 64'(e.addr));
            if (e.is_read) check("sb_rdata", 64'(m_rd_data), 64'(e.rd));
        end
        @(negedge clk);
        s_rdy    = '0;
        m_as_[m] = 1'b1;
        #1;
        check("rdy_after", 64'(m_rdy), 64'(0));
        check("rd_after", 64'(m_rd_data), 64'(0));
        check("grant_after", 64'(m_grnt_), 64'(gnt_for(m)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_rdy;
        reset     = 1'b1;
        m_req_    = '1;
        m_as_     = '1;
        m_rw      = '1;
        m_busy    = '0;
        m_addr    = '0;
        m_wr_data = '0;
        s_rdy     = '0;
        for (int j = 0; j < NS; j++) s_rd_data[j*DW +: DW] = slave_word(j);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_grant", 64'(m_grnt_), 64'(4'hF));
        check("rst_s_as", 64'(s_as_), 64'(1));
        check("rst_htrans", 64'(htrans), 64'(0));
        check("rst_cs", 64'(s_cs_), 64'(8'hFF));
        check("rst_rdy", 64'(m_rdy), 64'(0));
        check("rst_err", 64'(m_err), 64'(0));
        check("rst_rd_data", 64'(m_rd_data), 64'(0));

        // Single requester m2: grant one cycle later
        reset  = 1'b0;
        m_req_ = 4'b1011;
        gq.push_back(2);
        #1;
        check("grant_not_yet", 64'(m_grnt_), 64'(4'hF));
        @(negedge clk);
        check_grant();
        check("own_htrans_idle", 64'(htrans), 64'(0));
        check("own_s_as", 64'(s_as_), 64'(1));
        m_busy[2] = 1'b1;
        #1;
        check("htrans_busy", 64'(htrans), 64'(2'b01));
        m_busy[2] = 1'b0;

        // Write to slave 3 with 3 wait cycles, then back-to-back read from slave 5
        do_xfer(2, 32'h6000_0010, 1'b0, 32'hCAFE_F00D, 3, 1'b0);
        do_xfer(2, 32'hA000_0004, 1'b1, 32'h0, 0, 1'b0);

        // Owner drops req_ mid-WAIT: lock holds until completion, then rotate to m3
        m_req_[0] = 1'b0;
        m_req_[3] = 1'b0;
        do_xfer(2, 32'h2000_0000, 1'b1, 32'h0, 2, 1'b1);
        gq.push_back(3);
        @(negedge clk);
        check_grant();
        m_req_[3] = 1'b1;
        gq.push_back(0);
        @(negedge clk);
        check_grant();
        m_req_ = '1;
        @(negedge clk);
        check("idle_after_release", 64'(m_grnt_), 64'(4'hF));

        // Full rotation from a fresh pointer with everyone requesting
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        m_req_ = '0;
        gq.push_back(0);
        gq.push_back(1);
        gq.push_back(2);
        gq.push_back(3);
        gq.push_back(0);
        @(negedge clk);
        check_grant();
        for (int i = 0; i < NM; i++) begin
            do_xfer(i, {3'(2 * i + 1), 29'h0000_0100 + 29'(i)}, 1'b1, 32'h0, i % 3, 1'b0);
            m_req_[i] = 1'b1;
            @(negedge clk);
            check_grant();
            m_req_[i] = 1'b0;
        end

        // Reset while m0 waits on slave 2: no completion pulse, bus idles
        m_as_[0]          = 1'b0;
        m_rw[0]           = 1'b1;
        m_addr[0 +: AW]   = 32'h4000_0000;
        @(negedge clk);
        s_rdy[2] = 1'b1;
        reset    = 1'b1;
        #1;
        check("abort_rdy", 64'(m_rdy), 64'(0));
        @(negedge clk);
        check("abort_grant", 64'(m_grnt_), 64'(4'hF));
        check("abort_s_as", 64'(s_as_), 64'(1));
        check("abort_htrans", 64'(htrans), 64'(0));
        check("abort_cs", 64'(s_cs_), 64'(8'hFF));
        check("abort_rdy_next", 64'(m_rdy), 64'(0));
        reset  = 1'b0;
        m_as_  = '1;
        s_rdy  = '0;
        m_req_ = '1;

        // Slave 4 never ready
        m_req_[1] = 1'b0;
        gq.push_back(1);
        @(negedge clk);
        check_grant();
        m_as_[1]          = 1'b0;
        m_rw[1]           = 1'b1;
        m_addr[AW +: AW]  = 32'h8000_0000;
`ifdef BUS_TIMEOUT_EN
        for (int c = 1; c <= TB_TIMEOUT; c++) begin
            @(negedge clk);
            #1;
            if (c < TB_TIMEOUT) begin
                check("to_rdy_early", 64'(m_rdy), 64'(0));
            end else begin
                check("to_rdy", 64'(m_rdy), 64'(1));
                check("to_err", 64'(m_err), 64'(1));
                check("to_rd_data", 64'(m_rd_data), 64'(0));
            end
        end
        @(negedge clk);
        m_as_[1] = 1'b1;
        #1;
        check("to_rdy_after", 64'(m_rdy), 64'(0));
        check("to_err_after", 64'(m_err), 64'(0));
        check("to_grant_kept", 64'(m_grnt_), 64'(gnt_for(1)));
`else
        bad_rdy = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            #1;
            if (m_rdy !== 1'b0 || m_err !== 1'b0) bad_rdy++;
        end
        check("no_timeout", 64'(bad_rdy), 64'(0));
        check("wait_grant_kept", 64'(m_grnt_), 64'(gnt_for(1)));
        @(negedge clk);
        s_rdy[4] = 1'b1;
        #1;
        check("late_rdy", 64'(m_rdy), 64'(1));
        check("late_rd_data", 64'(m_rd_data), 64'(slave_word(4)));
        @(negedge clk);
        s_rdy    = '0;
        m_as_[1] = 1'b1;
`endif
        m_req_ = '1;
        @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'(0));
        check("gq_empty", 64'(gq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
